// File: rtl/demux_1x8_dispatch_if.sv
// Handshake bundle between the upstream producer, the round-robin dispatcher
// and the 8 downstream consumers.
// Optional macro DEMUX_XFER_CNT_EN adds the per-channel xfer_cnt bus.
interface demux_1x8_dispatch_if #(
  parameter int WIDTH = 8
`ifdef DEMUX_XFER_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [7:0]       chan_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       sel;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef DEMUX_XFER_CNT_EN
  logic [8*CNT_W-1:0] xfer_cnt;

  // environment side: drives upstream word and consumer readies
  modport master (
    output chan_en, in_valid, in_data, out_ready,
    input  in_ready, sel, out_valid, out_data, busy, xfer_cnt
  );
  // dispatcher side
  modport slave (
    input  chan_en, in_valid, in_data, out_ready,
    output in_ready, sel, out_valid, out_data, busy, xfer_cnt
  );
`else
  // environment side: drives upstream word and consumer readies
  modport master (
    output chan_en, in_valid, in_data, out_ready,
    input  in_ready, sel, out_valid, out_data, busy
  );
  // dispatcher side
  modport slave (
    input  chan_en, in_valid, in_data, out_ready,
    output in_ready, sel, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/demux_1x8_dispatch.sv
// Round-robin 1x8 dispatcher: holds one word, picks the next enabled channel
// starting at the round-robin pointer, and handshakes with that consumer.
// Optional macro DEMUX_XFER_CNT_EN adds saturating per-channel delivery counters.

`ifdef DEMUX_XFER_CNT_EN
// One saturating delivery counter per channel.
module demux_1x8_dispatch_cnt_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // increment on delivery, stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module demux_1x8_dispatch #(
  parameter int WIDTH = 8
`ifdef DEMUX_XFER_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1x8_dispatch_if.slave  bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             any_en;
  logic [2:0]       base;
  logic [15:0]      rot_full;
  logic [7:0]       rot;
  logic [2:0]       off;
  logic [2:0]       nxt;
  logic             xfer;
  logic             in_ready;
  logic [7:0]       out_valid;
  logic             busy;

  assign any_en = |bus.chan_en;

  // after a delivery in SEND the search restarts just past the served channel,
  // which is exactly where ptr will land on the same edge
  assign base = (state_q == SEND) ? (sel_q + 3'd1) : ptr_q;

  // rotate the enable mask so that bit 0 is the search start, then take the
  // lowest set bit; nxt is only used when any_en is set
  always_comb begin
    rot_full = {bus.chan_en, bus.chan_en} >> base;
    rot      = rot_full[7:0];
    off      = 3'd0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
    nxt = base + off;
  end

  // next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 8'h00;
    busy      = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = any_en;
        if (bus.in_valid && any_en) begin
          data_d  = bus.in_data;
          sel_d   = nxt;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 8'h01 << sel_q;
        busy      = 1'b1;
        // only the selected consumer's ready matters
        xfer      = bus.out_ready[sel_q];
        in_ready  = xfer & any_en;
        if (xfer) begin
          ptr_d = sel_q + 3'd1;
          if (bus.in_valid && any_en) begin
            data_d = bus.in_data;
            sel_d  = nxt;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, select, pointer and held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;

`ifdef DEMUX_XFER_CNT_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_cnt
    demux_1x8_dispatch_cnt_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .inc_i (xfer && (sel_q == 3'(i))),
      .cnt_o (cnt[i])
    );
  end

  assign bus.xfer_cnt = cnt;
`endif
endmodule

// File: tb/tb_demux_1x8_dispatch.sv
// Bench for demux_1x8_dispatch: directed vector table, hand sequences for the
// stall / mask / reset corners, then randomized traffic against a
// transaction-level model (held word, target channel, round-robin start).
// Build with DEMUX_XFER_CNT_EN to also exercise the saturating counters.
module tb_demux_1x8_dispatch;
  localparam int WIDTH = 8;
`ifdef DEMUX_XFER_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;

  demux_1x8_dispatch_if #(
    .WIDTH(WIDTH)
`ifdef DEMUX_XFER_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  demux_1x8_dispatch #(
    .WIDTH(WIDTH)
`ifdef DEMUX_XFER_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  bit         m_hold;
  logic [7:0] m_word;
  int         m_tgt;
  int         m_rr;
  int         m_cnt[8];

  // last applied inputs, consumed by tick()
  logic [7:0] a_en, a_d, a_rdy;
  logic       a_v;

  typedef struct {
    logic [7:0] en;
    logic       v;
    logic [7:0] d;
    logic [7:0] rdy;
    logic       e_ir;
    logic [2:0] e_sel;
    logic [7:0] e_ov;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int pick(input int from, input logic [7:0] en);
    for (int o = 0; o < 8; o++) begin
      if (en[(from + o) % 8]) return (from + o) % 8;
    end
    return 0;
  endfunction

  function automatic void m_reset();
    m_hold = 0; m_word = 8'h00; m_tgt = 0; m_rr = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endfunction

  function automatic logic m_ir(input logic [7:0] en, input logic [7:0] rdy);
    return m_hold ? (rdy[m_tgt] && en != 0) : (en != 0);
  endfunction

  // drive inputs just after an edge, then check all outputs mid-cycle
  task automatic apply(input logic [7:0] en, input logic v, input logic [7:0] d,
                       input logic [7:0] rdy);
    a_en = en; a_v = v; a_d = d; a_rdy = rdy;
    bus.chan_en = en; bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
    #3;
    chk("m_in_ready",  32'(bus.in_ready),  32'(m_ir(en, rdy)));
    chk("m_out_valid", 32'(bus.out_valid), m_hold ? (32'd1 << m_tgt) : 32'd0);
    chk("m_sel",       32'(bus.sel),       32'(m_tgt));
    chk("m_out_data",  32'(bus.out_data),  32'(m_word));
    chk("m_busy",      32'(bus.busy),      32'(m_hold));
`ifdef DEMUX_XFER_CNT_EN
    begin
      logic [8*CNT_W-1:0] e;
      for (int i = 0; i < 8; i++) e[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      chk("m_xfer_cnt", 32'(bus.xfer_cnt), 32'(e));
    end
`endif
  endtask

  // clock edge: advance the model with the inputs applied this cycle
  task automatic tick();
    bit fire, done;
    fire = a_v && m_ir(a_en, a_rdy);
    done = m_hold && a_rdy[m_tgt];
    @(posedge clk);
    if (done) begin
`ifdef DEMUX_XFER_CNT_EN
      if (m_cnt[m_tgt] < (1 << CNT_W) - 1) m_cnt[m_tgt]++;
`endif
      m_rr = (m_tgt + 1) % 8;
    end
    if (fire) begin
      m_tgt  = pick(m_rr, a_en);
      m_word = a_d;
      m_hold = 1;
    end else if (done) begin
      m_hold = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_sel",       32'(bus.sel),       32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    bus.chan_en = 8'h00; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 8'h00;
    a_en = 8'h00; a_v = 1'b0; a_d = 8'h00; a_rdy = 8'h00;
    m_reset();

    // all channels, back-to-back stream 0x10..0x18, then drain
    tbl.push_back('{8'hFF, 1'b1, 8'h10, 8'hFF, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{8'hFF, 1'b1, 8'(8'h10 + k), 8'hFF, 1'b1, 3'(k - 1),
                      8'(8'h01 << (k - 1)), 8'(8'h10 + k - 1), 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 8'h01, 8'h18, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd0, 8'h00, 8'h18, 1'b0});
    // sparse mask 1010_0100: 2,5,7,2
    tbl.push_back('{8'hA4, 1'b1, 8'h20, 8'hFF, 1'b1, 3'd0, 8'h00, 8'h18, 1'b0});
    tbl.push_back('{8'hA4, 1'b1, 8'h21, 8'hFF, 1'b1, 3'd2, 8'h04, 8'h20, 1'b1});
    tbl.push_back('{8'hA4, 1'b1, 8'h22, 8'hFF, 1'b1, 3'd5, 8'h20, 8'h21, 1'b1});
    tbl.push_back('{8'hA4, 1'b1, 8'h23, 8'hFF, 1'b1, 3'd7, 8'h80, 8'h22, 1'b1});
    tbl.push_back('{8'hA4, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd2, 8'h04, 8'h23, 1'b1});
    tbl.push_back('{8'hA4, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd2, 8'h00, 8'h23, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_sel", i),       32'(bus.sel),       32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i),  32'(bus.out_data),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_busy", i),      32'(bus.busy),      32'(tbl[i].e_busy));
      tick();
    end

    // stall on ch3 with 0xA5 for 5 cycles, then release
    apply(8'hFF, 1'b1, 8'hA5, 8'hFF); tick();
    for (int k = 0; k < 5; k++) begin
      apply(8'hFF, 1'b1, 8'h77, 8'hF7);
      chk("stall_out_valid", 32'(bus.out_valid), 32'h08);
      chk("stall_out_data",  32'(bus.out_data),  32'hA5);
      chk("stall_in_ready",  32'(bus.in_ready),  32'h0);
      tick();
    end
    apply(8'hFF, 1'b0, 8'h00, 8'hFF);
    chk("release_out_valid", 32'(bus.out_valid), 32'h08);
    chk("release_in_ready",  32'(bus.in_ready),  32'h1);
    tick();
    apply(8'hFF, 1'b0, 8'h00, 8'hFF);
    chk("release_idle_busy", 32'(bus.busy), 32'h0);
    tick();

    // no channel enabled: nothing accepted, nothing driven
    for (int k = 0; k < 3; k++) begin
      apply(8'h00, 1'b1, 8'h55, 8'hFF);
      chk("noen_in_ready",  32'(bus.in_ready),  32'h0);
      chk("noen_out_valid", 32'(bus.out_valid), 32'h0);
      tick();
    end

    // mask ch4 while it is being served: still delivered, later skipped
    apply(8'hFF, 1'b1, 8'h44, 8'hFF); tick();
    apply(8'hEF, 1'b0, 8'h00, 8'h00);
    chk("mask4_out_valid", 32'(bus.out_valid), 32'h10);
    tick();
    apply(8'hEF, 1'b0, 8'h00, 8'hFF);
    chk("mask4_deliver", 32'(bus.out_valid), 32'h10);
    chk("mask4_data",    32'(bus.out_data),  32'h44);
    tick();
    for (int k = 0; k < 8; k++) begin
      apply(8'hEF, 1'b1, 8'(8'h60 + k), 8'hFF);
      tick();
    end
    apply(8'hEF, 1'b0, 8'h00, 8'hFF);
    chk("skip4_sel",  32'(bus.sel),      32'h5);
    chk("skip4_data", 32'(bus.out_data), 32'h67);
    tick();

    // reset while a word is held
    apply(8'hFF, 1'b1, 8'h99, 8'h00); tick();
    apply(8'hFF, 1'b0, 8'h00, 8'h00); tick();
    do_reset();
    apply(8'hFF, 1'b0, 8'h00, 8'h00);
    chk("postrst_in_ready",  32'(bus.in_ready),  32'h1);
    chk("postrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("postrst_busy",      32'(bus.busy),      32'h0);
    chk("postrst_sel",       32'(bus.sel),       32'h0);
    tick();

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [7:0] en;
      if ($urandom_range(0, 99) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       en = 8'h00;
        1:       en = 8'h01 << $urandom_range(0, 7);
        default: en = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) en = 8'h00;
      apply(en, 1'($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF);
      tick();
    end

`ifdef DEMUX_XFER_CNT_EN
    // 5 words to ch1 only with a 2-bit counter: saturates at 3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(8'h02, 1'b1, 8'(k), 8'hFF);
      tick();
    end
    apply(8'h02, 1'b0, 8'h00, 8'hFF); tick();
    apply(8'h02, 1'b0, 8'h00, 8'hFF);
    chk("cnt_sat_ch1", 32'(bus.xfer_cnt), 32'h000C);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
